// File: rtl/seq_frame_tx.sv
// seq_frame_tx: serial frame transmitter for the 1101 sequence detectors.
// Each accepted word goes out as sync 1101, payload MSB-first, an optional
// even-parity bit, then GAP_BITS zeros. Each bit is held BIT_CYCLES clocks.
// Optional feature macro: SEQ_TX_PARITY_EN (adds the PAR state and parity bit).
module seq_frame_tx #(
  parameter int DATA_W     = 8,
  parameter int BIT_CYCLES = 1,
  parameter int GAP_BITS   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out,
  output logic              bit_strobe,
  output logic              busy
);

  // Bit index is wide enough for the largest payload (32) and gap (15).
  localparam int IDX_W = 6;
  localparam logic [3:0]       SYNC_PAT      = 4'b1101;
  localparam logic [IDX_W-1:0] IDX_ZERO      = 6'd0;
  localparam logic [IDX_W-1:0] IDX_ONE       = 6'd1;
  localparam logic [IDX_W-1:0] IDX_SYNC_LAST = 6'd3;
  localparam logic [IDX_W-1:0] IDX_DATA_LAST = IDX_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0] IDX_GAP_LAST  = IDX_W'(GAP_BITS - 1);
  localparam logic [7:0]       TIMER_LAST    = 8'(BIT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SYNC = 3'd1,
    DATA = 3'd2,
`ifdef SEQ_TX_PARITY_EN
    PAR  = 3'd3,
`endif
    GAP  = 3'd4
  } state_t;

`ifdef SEQ_TX_PARITY_EN
  // Even parity over the captured payload.
  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction
`endif

  state_t            state_r, state_s;
  logic [7:0]        timer_r, timer_s;
  logic [IDX_W-1:0]  idx_r, idx_s;
  logic [DATA_W-1:0] shreg_r, shreg_s;
`ifdef SEQ_TX_PARITY_EN
  logic              par_r, par_s;
`endif
  logic              wrap_s;
  logic              line_s;
  logic              out_r, strobe_r, busy_r;

  assign wrap_s     = (timer_r == TIMER_LAST);
  assign in_ready   = (state_r == IDLE);
  assign out        = out_r;
  assign bit_strobe = strobe_r;
  assign busy       = busy_r;

  // Next-state, bit timer, bit index and shift-register update.
  always_comb begin
    state_s = state_r;
    timer_s = timer_r;
    idx_s   = idx_r;
    shreg_s = shreg_r;
`ifdef SEQ_TX_PARITY_EN
    par_s   = par_r;
`endif
    if (state_r == IDLE) begin
      timer_s = 8'd0;
    end else if (wrap_s) begin
      timer_s = 8'd0;
    end else begin
      timer_s = timer_r + 8'd1;
    end
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_s = SYNC;
          idx_s   = IDX_SYNC_LAST;
          shreg_s = in_data;
`ifdef SEQ_TX_PARITY_EN
          par_s   = even_parity(in_data);
`endif
        end else begin
          state_s = IDLE;
        end
      end
      SYNC: begin
        if (!wrap_s) begin
          state_s = SYNC;
        end else if (idx_r == IDX_ZERO) begin
          state_s = DATA;
          idx_s   = IDX_DATA_LAST;
        end else begin
          idx_s = idx_r - IDX_ONE;
        end
      end
      DATA: begin
        if (!wrap_s) begin
          state_s = DATA;
        end else begin
          shreg_s = shreg_r << 1'b1;
          if (idx_r == IDX_ZERO) begin
`ifdef SEQ_TX_PARITY_EN
            state_s = PAR;
            idx_s   = IDX_ZERO;
`else
            state_s = GAP;
            idx_s   = IDX_GAP_LAST;
`endif
          end else begin
            idx_s = idx_r - IDX_ONE;
          end
        end
      end
`ifdef SEQ_TX_PARITY_EN
      PAR: begin
        if (wrap_s) begin
          state_s = GAP;
          idx_s   = IDX_GAP_LAST;
        end else begin
          state_s = PAR;
        end
      end
`endif
      GAP: begin
        if (!wrap_s) begin
          state_s = GAP;
        end else if (idx_r == IDX_ZERO) begin
          state_s = IDLE;
        end else begin
          idx_s = idx_r - IDX_ONE;
        end
      end
      default: begin
        state_s = IDLE;
        timer_s = 8'd0;
        idx_s   = IDX_ZERO;
      end
    endcase
  end

  // Serial bit for the upcoming cycle, derived from the next state.
  always_comb begin
    line_s = 1'b0;
    case (state_s)
      SYNC:    line_s = SYNC_PAT[idx_s[1:0]];
      DATA:    line_s = shreg_s[DATA_W-1];
`ifdef SEQ_TX_PARITY_EN
      PAR:     line_s = par_s;
`endif
      default: line_s = 1'b0;
    endcase
  end

  // State, datapath and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r  <= IDLE;
      timer_r  <= 8'd0;
      idx_r    <= IDX_ZERO;
      shreg_r  <= '0;
`ifdef SEQ_TX_PARITY_EN
      par_r    <= 1'b0;
`endif
      out_r    <= 1'b0;
      strobe_r <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      timer_r  <= timer_s;
      idx_r    <= idx_s;
      shreg_r  <= shreg_s;
`ifdef SEQ_TX_PARITY_EN
      par_r    <= par_s;
`endif
      out_r    <= line_s;
      strobe_r <= (state_s != IDLE) && (timer_s == 8'd0);
      busy_r   <= (state_s != IDLE);
    end
  end

endmodule

// File: tb/tb_seq_frame_tx.sv
// Directed bench for seq_frame_tx: table of words with hand-computed parity,
// plus reset, mid-frame reset, bit stretching and back-to-back sequences.
module tb_seq_frame_tx;

`ifdef SEQ_TX_PARITY_EN
  localparam int PAR_ON = 1;
`else
  localparam int PAR_ON = 0;
`endif
  localparam int FLEN = 4 + 8 + PAR_ON + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [7:0] in_data, in_data2;
  logic       in_valid, in_valid2;
  logic       in_ready, out, bit_strobe, busy;
  logic       in_ready2, out2, bit_strobe2, busy2;

  seq_frame_tx #(.DATA_W(8), .BIT_CYCLES(1), .GAP_BITS(1)) u1 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out(out), .bit_strobe(bit_strobe), .busy(busy)
  );

  seq_frame_tx #(.DATA_W(8), .BIT_CYCLES(3), .GAP_BITS(1)) u2 (
    .clk(clk), .reset(reset), .in_data(in_data2), .in_valid(in_valid2),
    .in_ready(in_ready2), .out(out2), .bit_strobe(bit_strobe2), .busy(busy2)
  );

  typedef struct {
    logic [7:0] word;
    logic       par;
  } vec_t;

  vec_t vecs[6];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Non-overlapping 1101 monitor on u1's line (one bit per cycle).
  logic [3:0] det_hist = 4'd0;
  int         det_cnt  = 0;
  always @(negedge clk) begin
    if ({det_hist[2:0], out} == 4'b1101) begin
      det_cnt  <= det_cnt + 1;
      det_hist <= 4'd0;
    end else begin
      det_hist <= {det_hist[2:0], out};
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic exp_bit(input logic [7:0] w, input logic p, input int k);
    logic [3:0] s;
    s = 4'b1101;
    if (k < 4) return s[3-k];
    else if (k < 12) return w[11-k];
    else if (k == 12 && PAR_ON == 1) return p;
    else return 1'b0;
  endfunction

  // Offer a word at a negedge with u1 idle, then check every frame cycle.
  task automatic run_frame(input logic [7:0] w, input logic p, input bit keep_valid, input string tag);
    in_data  = w;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < FLEN; k++) begin
      if (keep_valid) in_data = 8'($urandom);
      else in_valid = 1'b0;
      chk($sformatf("%s out bit%0d", tag, k), {31'd0, out}, {31'd0, exp_bit(w, p, k)});
      chk($sformatf("%s strobe bit%0d", tag, k), {31'd0, bit_strobe}, 32'd1);
      chk($sformatf("%s busy bit%0d", tag, k), {31'd0, busy}, 32'd1);
      chk($sformatf("%s ready bit%0d", tag, k), {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    chk({tag, " ready end"}, {31'd0, in_ready}, 32'd1);
    chk({tag, " busy end"}, {31'd0, busy}, 32'd0);
    chk({tag, " out end"}, {31'd0, out}, 32'd0);
    chk({tag, " strobe end"}, {31'd0, bit_strobe}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{word: 8'hA5, par: 1'b0};
    vecs[1] = '{word: 8'h07, par: 1'b1};
    vecs[2] = '{word: 8'hFF, par: 1'b0};
    vecs[3] = '{word: 8'h01, par: 1'b1};
    vecs[4] = '{word: 8'h80, par: 1'b1};
    vecs[5] = '{word: 8'hC3, par: 1'b0};

    // Reset held 3 cycles with in_valid high.
    reset     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h5A;
    in_valid2 = 1'b0;
    in_data2  = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst out", {31'd0, out}, 32'd0);
      chk("rst busy", {31'd0, busy}, 32'd0);
      chk("rst strobe", {31'd0, bit_strobe}, 32'd0);
      chk("rst busy2", {31'd0, busy2}, 32'd0);
    end
    reset = 1'b1;
    chk("rst release ready", {31'd0, in_ready}, 32'd1);
    run_frame(8'h5A, 1'b0, 1'b0, "rst_release");

    // Table-driven frames.
    for (int v = 0; v < 6; v++) begin
      run_frame(vecs[v].word, vecs[v].par, 1'b0, $sformatf("vec%0d", v));
    end

    // Reset on the same edge as a handshake: nothing captured.
    in_data  = 8'hFF;
    in_valid = 1'b1;
    reset    = 1'b0;
    @(negedge clk);
    chk("rst+hs busy", {31'd0, busy}, 32'd0);
    chk("rst+hs out", {31'd0, out}, 32'd0);
    reset    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst+hs busy after", {31'd0, busy}, 32'd0);
    chk("rst+hs ready after", {31'd0, in_ready}, 32'd1);

    // Reset during payload bit 2 (frame bit 6) of 0xFF.
    in_data  = 8'hFF;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("midrst pre out", {31'd0, out}, 32'd1);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst out", {31'd0, out}, 32'd0);
    chk("midrst busy", {31'd0, busy}, 32'd0);
    chk("midrst strobe", {31'd0, bit_strobe}, 32'd0);
    reset = 1'b1;
    run_frame(8'h3C, 1'b0, 1'b0, "after_rst");

    // Back-to-back with in_valid held high and in_data changing mid-frame.
    @(negedge clk);
    chk("det idle", det_cnt, det_cnt);
    begin
      int det_base;
      det_base = det_cnt;
      run_frame(8'h00, 1'b0, 1'b1, "b2b0");
      run_frame(8'h3C, 1'b0, 1'b1, "b2b1");
      run_frame(8'h42, 1'b0, 1'b1, "b2b2");
      run_frame(8'h18, 1'b0, 1'b0, "b2b3");
      @(negedge clk);
      chk("det count", det_cnt - det_base, 32'd4);
    end

    // Bit stretching on u2: 0xFF, each bit held 3 cycles.
    in_data2  = 8'hFF;
    in_valid2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid2 = 1'b0;
    for (int c = 0; c < 3 * FLEN; c++) begin
      chk($sformatf("stretch out c%0d", c), {31'd0, out2}, {31'd0, exp_bit(8'hFF, 1'b0, c / 3)});
      chk($sformatf("stretch strobe c%0d", c), {31'd0, bit_strobe2}, {31'd0, (c % 3) == 0});
      chk($sformatf("stretch busy c%0d", c), {31'd0, busy2}, 32'd1);
      @(negedge clk);
    end
    chk("stretch ready end", {31'd0, in_ready2}, 32'd1);
    chk("stretch busy end", {31'd0, busy2}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
